proc_inst_dcod_pipe: RTL and testbench

- Registered instruction-decode stage with valid/ready handshakes on input and output; successor to the combinational opcode-only parser.
- Accepts 32-bit MIPS-format instruction words from fetch, buffers up to 2 in a skid FIFO, and presents fully decoded fields to the register-read stage.
- Adds decode of every field, immediate extension to XLEN, instruction-type classification, flush, and a delivered-instruction counter.

---
 rtl/proc_inst_dcod_pipe.sv | 151 +++++++++++++++
 tb/tb_proc_inst_dcod_pipe.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/proc_inst_dcod_pipe.sv
// -----------------------------------------------------------------------------
// proc_inst_dcod_pipe
// Registered MIPS instruction-decode stage. Raw instruction words from fetch
// are buffered in a two-entry skid FIFO. The head entry is decoded
// combinationally into every instruction field for the register-read stage.
//
// Ports
//   i_clk        rising-edge clock
//   i_rst_n      asynchronous active-low reset
//   i_flush      synchronous flush; empties the FIFO and discards this
//                cycle's accept/deliver
//   i_inst_vld   fetch offers i_inst_prse
//   i_inst_prse  32-bit instruction word
//   o_inst_rdy   stage can accept (depends only on registered occupancy)
//   o_dcod_vld   a decoded instruction is presented
//   i_dcod_rdy   downstream accepts the presented instruction
//   o_inst_*     decoded fields of the head word (all zero when not valid)
//   o_inst_type  00 R, 01 I, 10 J
//   o_dcod_cnt   instructions delivered since reset (wraps)
// -----------------------------------------------------------------------------
module proc_inst_dcod_pipe #(
   parameter int INST_WIDTH = 5,
   parameter int XLEN       = 32,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_flush,
   input  logic                     i_inst_vld,
   input  logic [2**INST_WIDTH-1:0] i_inst_prse,
   output logic                     o_inst_rdy,
   output logic                     o_dcod_vld,
   input  logic                     i_dcod_rdy,
   output logic [5:0]               o_inst_opcd,
   output logic [4:0]               o_inst_rs,
   output logic [4:0]               o_inst_rt,
   output logic [4:0]               o_inst_rd,
   output logic [4:0]               o_inst_shmt,
   output logic [5:0]               o_inst_fnct,
   output logic [XLEN-1:0]          o_inst_imm,
   output logic [25:0]              o_inst_jtgt,
   output logic [1:0]               o_inst_type,
   output logic [CNT_WIDTH-1:0]     o_dcod_cnt
);

   localparam int IW = 2**INST_WIDTH;

   // Only the 32-bit MIPS encoding is decoded; anything else is a build error.
   if (INST_WIDTH != 5) begin : g_bad_inst_width
      $error("proc_inst_dcod_pipe: INST_WIDTH must be 5");
   end
   if (XLEN < 16) begin : g_bad_xlen
      $error("proc_inst_dcod_pipe: XLEN must be >= 16");
   end

   // ANDI/ORI/XORI take a zero-extended immediate; all others sign-extend.
   function automatic logic [XLEN-1:0] ext_imm(input logic [5:0]  opcd,
                                               input logic [15:0] imm16);
      logic signed [15:0] simm;
      simm = imm16;
      if (opcd == 6'h0C || opcd == 6'h0D || opcd == 6'h0E)
         ext_imm = XLEN'(imm16);
      else
         ext_imm = XLEN'(simm);
   endfunction

   function automatic logic [1:0] inst_type(input logic [5:0] opcd);
      if (opcd == 6'h00)
         inst_type = 2'b00;
      else if (opcd == 6'h02 || opcd == 6'h03)
         inst_type = 2'b10;
      else
         inst_type = 2'b01;
   endfunction

   logic [IW-1:0]        mem_p0 [2];
   logic                 wr_ptr_p0;
   logic                 rd_ptr_p0;
   logic [1:0]           cnt_p0;
   logic [CNT_WIDTH-1:0] dcod_cnt_p0;
   logic                 vld_p0;
   logic                 accept;
   logic                 deliver;
   logic [IW-1:0]        head_p0;

   assign vld_p0     = (cnt_p0 != 2'd0);
   assign o_inst_rdy = (cnt_p0 != 2'd2);
   assign o_dcod_vld = vld_p0;
   assign o_dcod_cnt = dcod_cnt_p0;
   assign accept     = i_inst_vld & o_inst_rdy;
   assign deliver    = vld_p0 & i_dcod_rdy;

   // ---- stage p0: FIFO control (reset) ----
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_ptr_p0   <= 1'b0;
         rd_ptr_p0   <= 1'b0;
         cnt_p0      <= 2'd0;
         dcod_cnt_p0 <= '0;
      end else if (i_flush) begin
         wr_ptr_p0 <= 1'b0;
         rd_ptr_p0 <= 1'b0;
         cnt_p0    <= 2'd0;
      end else begin
         if (accept)
            wr_ptr_p0 <= wr_ptr_p0 + 1'b1;
         if (deliver) begin
            rd_ptr_p0   <= rd_ptr_p0 + 1'b1;
            dcod_cnt_p0 <= dcod_cnt_p0 + CNT_WIDTH'(1);
         end
         if (accept && !deliver)
            cnt_p0 <= cnt_p0 + 2'd1;
         else if (!accept && deliver)
            cnt_p0 <= cnt_p0 - 2'd1;
      end
   end

   // FIFO storage carries no reset; empty entries are never observed because
   // every decoded output is gated by vld_p0.
   always_ff @(posedge i_clk) begin
      if (accept && !i_flush)
         mem_p0[wr_ptr_p0] <= i_inst_prse;
   end

   assign head_p0 = mem_p0[rd_ptr_p0];

   // ---- decode of head entry (combinational) ----
   always_comb begin
      o_inst_opcd = '0;
      o_inst_rs   = '0;
      o_inst_rt   = '0;
      o_inst_rd   = '0;
      o_inst_shmt = '0;
      o_inst_fnct = '0;
      o_inst_imm  = '0;
      o_inst_jtgt = '0;
      o_inst_type = '0;
      if (vld_p0) begin
         o_inst_opcd = head_p0[31:26];
         o_inst_rs   = head_p0[25:21];
         o_inst_rt   = head_p0[20:16];
         o_inst_rd   = head_p0[15:11];
         o_inst_shmt = head_p0[10:6];
         o_inst_fnct = head_p0[5:0];
         o_inst_imm  = ext_imm(head_p0[31:26], head_p0[15:0]);
         o_inst_jtgt = head_p0[25:0];
         o_inst_type = inst_type(head_p0[31:26]);
      end
   end

endmodule

// File: tb/tb_proc_inst_dcod_pipe.sv
module tb_proc_inst_dcod_pipe;

   logic        i_clk;
   logic        i_rst_n;
   logic        i_flush;
   logic        i_inst_vld;
   logic [31:0] i_inst_prse;
   logic        o_inst_rdy;
   logic        o_dcod_vld;
   logic        i_dcod_rdy;
   logic [5:0]  o_inst_opcd;
   logic [4:0]  o_inst_rs;
   logic [4:0]  o_inst_rt;
   logic [4:0]  o_inst_rd;
   logic [4:0]  o_inst_shmt;
   logic [5:0]  o_inst_fnct;
   logic [31:0] o_inst_imm;
   logic [25:0] o_inst_jtgt;
   logic [1:0]  o_inst_type;
   logic [15:0] o_dcod_cnt;

   // Second instance with a narrow counter to observe wrap-around.
   logic        w_inst_rdy;
   logic        w_dcod_vld;
   logic [5:0]  w_inst_opcd;
   logic [4:0]  w_inst_rs;
   logic [4:0]  w_inst_rt;
   logic [4:0]  w_inst_rd;
   logic [4:0]  w_inst_shmt;
   logic [5:0]  w_inst_fnct;
   logic [31:0] w_inst_imm;
   logic [25:0] w_inst_jtgt;
   logic [1:0]  w_inst_type;
   logic [3:0]  w_dcod_cnt;

   int n_pass  = 0;
   int n_total = 0;

   proc_inst_dcod_pipe dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_flush(i_flush),
      .i_inst_vld(i_inst_vld), .i_inst_prse(i_inst_prse),
      .o_inst_rdy(o_inst_rdy), .o_dcod_vld(o_dcod_vld), .i_dcod_rdy(i_dcod_rdy),
      .o_inst_opcd(o_inst_opcd), .o_inst_rs(o_inst_rs), .o_inst_rt(o_inst_rt),
      .o_inst_rd(o_inst_rd), .o_inst_shmt(o_inst_shmt), .o_inst_fnct(o_inst_fnct),
      .o_inst_imm(o_inst_imm), .o_inst_jtgt(o_inst_jtgt), .o_inst_type(o_inst_type),
      .o_dcod_cnt(o_dcod_cnt)
   );

   proc_inst_dcod_pipe #(.CNT_WIDTH(4)) dut_w (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_flush(i_flush),
      .i_inst_vld(i_inst_vld), .i_inst_prse(i_inst_prse),
      .o_inst_rdy(w_inst_rdy), .o_dcod_vld(w_dcod_vld), .i_dcod_rdy(i_dcod_rdy),
      .o_inst_opcd(w_inst_opcd), .o_inst_rs(w_inst_rs), .o_inst_rt(w_inst_rt),
      .o_inst_rd(w_inst_rd), .o_inst_shmt(w_inst_shmt), .o_inst_fnct(w_inst_fnct),
      .o_inst_imm(w_inst_imm), .o_inst_jtgt(w_inst_jtgt), .o_inst_type(w_inst_type),
      .o_dcod_cnt(w_dcod_cnt)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   initial begin
      #2000000;
      $display("FAIL timeout total=%0d passed=%0d", n_total, n_pass);
      $fatal(1, "timeout");
   end

   // Advance past the next rising edge; outputs are settled when it returns.
   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic test_reset();
      i_rst_n = 1'b0; i_flush = 1'b0; i_inst_vld = 1'b0;
      i_inst_prse = 32'hFFFF_FFFF; i_dcod_rdy = 1'b0;
      step(); step();
      n_total++; if (o_dcod_vld !== 1'b0) $display("FAIL rst_vld got=%b exp=0", o_dcod_vld); else n_pass++;
      n_total++; if (o_inst_rdy !== 1'b1) $display("FAIL rst_rdy got=%b exp=1", o_inst_rdy); else n_pass++;
      n_total++; if (o_dcod_cnt !== 16'd0) $display("FAIL rst_cnt got=%0d exp=0", o_dcod_cnt); else n_pass++;
      n_total++;
      if ({o_inst_opcd, o_inst_jtgt, o_inst_imm, o_inst_type} !== 66'd0)
         $display("FAIL rst_fields opcd=%h jtgt=%h imm=%h type=%b exp all 0",
                  o_inst_opcd, o_inst_jtgt, o_inst_imm, o_inst_type);
      else n_pass++;
      i_rst_n = 1'b1;
      step();
      n_total++; if (o_dcod_vld !== 1'b0) $display("FAIL idle_vld got=%b exp=0", o_dcod_vld); else n_pass++;
   endtask

   task automatic test_rtype();
      i_dcod_rdy = 1'b1; i_inst_vld = 1'b1; i_inst_prse = 32'h012A_4020;
      step();
      i_inst_vld = 1'b0;
      n_total++; if (o_dcod_vld !== 1'b1) $display("FAIL r_vld got=%b exp=1", o_dcod_vld); else n_pass++;
      n_total++; if (o_inst_type !== 2'b00) $display("FAIL r_type got=%b exp=00", o_inst_type); else n_pass++;
      n_total++; if (o_inst_rs !== 5'd9) $display("FAIL r_rs got=%0d exp=9", o_inst_rs); else n_pass++;
      n_total++; if (o_inst_rt !== 5'd10) $display("FAIL r_rt got=%0d exp=10", o_inst_rt); else n_pass++;
      n_total++; if (o_inst_rd !== 5'd8) $display("FAIL r_rd got=%0d exp=8", o_inst_rd); else n_pass++;
      n_total++; if (o_inst_shmt !== 5'd0) $display("FAIL r_shmt got=%0d exp=0", o_inst_shmt); else n_pass++;
      n_total++; if (o_inst_fnct !== 6'h20) $display("FAIL r_fnct got=%h exp=20", o_inst_fnct); else n_pass++;
      n_total++; if (o_inst_imm !== 32'h0000_4020) $display("FAIL r_imm got=%h exp=00004020", o_inst_imm); else n_pass++;
      n_total++; if (o_inst_opcd !== 6'h00) $display("FAIL r_opcd got=%h exp=00", o_inst_opcd); else n_pass++;
      step();
      n_total++; if (o_dcod_cnt !== 16'd1) $display("FAIL r_cnt got=%0d exp=1", o_dcod_cnt); else n_pass++;
      n_total++; if (o_dcod_vld !== 1'b0) $display("FAIL r_empty_vld got=%b exp=0", o_dcod_vld); else n_pass++;
      n_total++; if (o_inst_fnct !== 6'h00) $display("FAIL r_gated_fnct got=%h exp=00", o_inst_fnct); else n_pass++;
   endtask

   task automatic test_extension();
      logic [31:0] words [3];
      logic [31:0] imms  [3];
      logic [1:0]  types [3];
      words[0] = 32'h2008_FFFF; imms[0] = 32'hFFFF_FFFF; types[0] = 2'b01;
      words[1] = 32'h3508_FFFF; imms[1] = 32'h0000_FFFF; types[1] = 2'b01;
      words[2] = 32'h0810_0004; imms[2] = 32'h0000_0004; types[2] = 2'b10;
      i_dcod_rdy = 1'b1;
      for (int i = 0; i < 3; i++) begin
         i_inst_vld = 1'b1; i_inst_prse = words[i];
         step();
         i_inst_vld = 1'b0;
         n_total++; if (o_inst_imm !== imms[i]) $display("FAIL ext_imm[%0d] got=%h exp=%h", i, o_inst_imm, imms[i]); else n_pass++;
         n_total++; if (o_inst_type !== types[i]) $display("FAIL ext_type[%0d] got=%b exp=%b", i, o_inst_type, types[i]); else n_pass++;
         n_total++; if (o_inst_jtgt !== words[i][25:0]) $display("FAIL ext_jtgt[%0d] got=%h exp=%h", i, o_inst_jtgt, words[i][25:0]); else n_pass++;
         step();
      end
      n_total++; if (o_inst_jtgt !== 26'd0) $display("FAIL ext_gated_jtgt got=%h exp=0", o_inst_jtgt); else n_pass++;
      n_total++; if (o_dcod_cnt !== 16'd4) $display("FAIL ext_cnt got=%0d exp=4", o_dcod_cnt); else n_pass++;
   endtask

   task automatic test_backpressure();
      logic [31:0] wa, wb, wc;
      wa = 32'h0022_1820; wb = 32'h8C43_0010; wc = 32'hAC64_0008;
      i_dcod_rdy = 1'b0;
      i_inst_vld = 1'b1; i_inst_prse = wa;
      step();
      n_total++; if (o_inst_rdy !== 1'b1) $display("FAIL bp_rdy1 got=%b exp=1", o_inst_rdy); else n_pass++;
      i_inst_prse = wb;
      step();
      n_total++; if (o_inst_rdy !== 1'b0) $display("FAIL bp_rdy2 got=%b exp=0", o_inst_rdy); else n_pass++;
      n_total++; if ({o_inst_opcd, o_inst_jtgt} !== wa) $display("FAIL bp_head_a got=%h exp=%h", {o_inst_opcd, o_inst_jtgt}, wa); else n_pass++;
      i_inst_prse = wc;
      step();
      n_total++; if (o_inst_rdy !== 1'b0) $display("FAIL bp_rdy3 got=%b exp=0", o_inst_rdy); else n_pass++;
      n_total++; if ({o_inst_opcd, o_inst_jtgt} !== wa) $display("FAIL bp_hold_a got=%h exp=%h", {o_inst_opcd, o_inst_jtgt}, wa); else n_pass++;
      n_total++; if (o_dcod_vld !== 1'b1) $display("FAIL bp_hold_vld got=%b exp=1", o_dcod_vld); else n_pass++;
      // Release: full FIFO delivers A but cannot take C in the same cycle.
      i_dcod_rdy = 1'b1;
      step();
      n_total++; if ({o_inst_opcd, o_inst_jtgt} !== wb) $display("FAIL bp_head_b got=%h exp=%h", {o_inst_opcd, o_inst_jtgt}, wb); else n_pass++;
      n_total++; if (o_inst_imm !== 32'h0000_0010) $display("FAIL bp_imm_b got=%h exp=00000010", o_inst_imm); else n_pass++;
      n_total++; if (o_inst_rdy !== 1'b1) $display("FAIL bp_rdy4 got=%b exp=1", o_inst_rdy); else n_pass++;
      step();
      i_inst_vld = 1'b0;
      n_total++; if ({o_inst_opcd, o_inst_jtgt} !== wc) $display("FAIL bp_head_c got=%h exp=%h", {o_inst_opcd, o_inst_jtgt}, wc); else n_pass++;
      step();
      n_total++; if (o_dcod_vld !== 1'b0) $display("FAIL bp_drain_vld got=%b exp=0", o_dcod_vld); else n_pass++;
      n_total++; if (o_dcod_cnt !== 16'd7) $display("FAIL bp_cnt got=%0d exp=7", o_dcod_cnt); else n_pass++;
   endtask

   task automatic stream(input int n);
      logic [31:0] w;
      i_dcod_rdy = 1'b1;
      for (int i = 0; i < n; i++) begin
         w = {6'h08, 5'd0, 5'd1, 16'(i * 3 + 1)};
         i_inst_vld = 1'b1; i_inst_prse = w;
         step();
         n_total++;
         if (o_dcod_vld !== 1'b1 || {o_inst_opcd, o_inst_jtgt} !== w)
            $display("FAIL stream[%0d] vld=%b word=%h exp vld=1 word=%h", i, o_dcod_vld, {o_inst_opcd, o_inst_jtgt}, w);
         else n_pass++;
      end
      i_inst_vld = 1'b0;
      step();
   endtask

   task automatic test_stream();
      i_rst_n = 1'b0;
      step();
      i_rst_n = 1'b1;
      stream(8);
      n_total++; if (o_dcod_cnt !== 16'd8) $display("FAIL stream_cnt got=%0d exp=8", o_dcod_cnt); else n_pass++;
      n_total++; if (o_dcod_vld !== 1'b0) $display("FAIL stream_vld got=%b exp=0", o_dcod_vld); else n_pass++;
   endtask

   task automatic test_flush();
      logic [31:0] wx, wy;
      wx = 32'h2010_1234; wy = 32'h3C01_ABCD;
      // Full FIFO, flush with fetch still offering.
      i_dcod_rdy = 1'b0; i_inst_vld = 1'b1; i_inst_prse = 32'h0000_0001;
      step();
      i_inst_prse = 32'h0000_0002;
      step();
      i_flush = 1'b1; i_dcod_rdy = 1'b1; i_inst_prse = wx;
      step();
      i_flush = 1'b0; i_inst_vld = 1'b0;
      n_total++; if (o_dcod_vld !== 1'b0) $display("FAIL fl_vld got=%b exp=0", o_dcod_vld); else n_pass++;
      n_total++; if (o_inst_rdy !== 1'b1) $display("FAIL fl_rdy got=%b exp=1", o_inst_rdy); else n_pass++;
      n_total++; if ({o_inst_opcd, o_inst_jtgt, o_inst_imm} !== 64'd0) $display("FAIL fl_fields got=%h exp=0", {o_inst_opcd, o_inst_jtgt, o_inst_imm}); else n_pass++;
      n_total++; if (o_dcod_cnt !== 16'd8) $display("FAIL fl_cnt got=%0d exp=8", o_dcod_cnt); else n_pass++;
      // One entry, flush while both accepting and delivering.
      i_dcod_rdy = 1'b0; i_inst_vld = 1'b1; i_inst_prse = 32'h0000_0003;
      step();
      i_flush = 1'b1; i_dcod_rdy = 1'b1; i_inst_prse = wx;
      step();
      i_flush = 1'b0; i_inst_vld = 1'b0;
      n_total++; if (o_dcod_vld !== 1'b0) $display("FAIL fl2_vld got=%b exp=0", o_dcod_vld); else n_pass++;
      n_total++; if (o_dcod_cnt !== 16'd8) $display("FAIL fl2_cnt got=%0d exp=8", o_dcod_cnt); else n_pass++;
      step();
      n_total++; if (o_dcod_vld !== 1'b0) $display("FAIL fl2_ghost got=%b exp=0", o_dcod_vld); else n_pass++;
      i_inst_vld = 1'b1; i_inst_prse = wy;
      step();
      i_inst_vld = 1'b0;
      n_total++; if ({o_inst_opcd, o_inst_jtgt} !== wy) $display("FAIL fl_next got=%h exp=%h", {o_inst_opcd, o_inst_jtgt}, wy); else n_pass++;
      step();
      n_total++; if (o_dcod_cnt !== 16'd9) $display("FAIL fl_next_cnt got=%0d exp=9", o_dcod_cnt); else n_pass++;
   endtask

   task automatic test_async_reset();
      i_dcod_rdy = 1'b0; i_inst_vld = 1'b1; i_inst_prse = 32'h2008_FFFF;
      step(); step();
      i_inst_vld = 1'b0;
      n_total++; if (o_inst_rdy !== 1'b0) $display("FAIL ar_full got=%b exp=0", o_inst_rdy); else n_pass++;
      #2;
      i_rst_n = 1'b0;
      #1;
      n_total++; if (o_dcod_vld !== 1'b0) $display("FAIL ar_vld got=%b exp=0", o_dcod_vld); else n_pass++;
      n_total++; if (o_inst_rdy !== 1'b1) $display("FAIL ar_rdy got=%b exp=1", o_inst_rdy); else n_pass++;
      n_total++; if (o_dcod_cnt !== 16'd0) $display("FAIL ar_cnt got=%0d exp=0", o_dcod_cnt); else n_pass++;
      n_total++; if ({o_inst_opcd, o_inst_imm, o_inst_type} !== 40'd0) $display("FAIL ar_fields got=%h exp=0", {o_inst_opcd, o_inst_imm, o_inst_type}); else n_pass++;
      step();
      i_rst_n = 1'b1;
      step();
      n_total++; if (o_dcod_vld !== 1'b0) $display("FAIL ar_after got=%b exp=0", o_dcod_vld); else n_pass++;
   endtask

   task automatic test_wrap();
      stream(17);
      n_total++; if (o_dcod_cnt !== 16'd17) $display("FAIL wrap_wide got=%0d exp=17", o_dcod_cnt); else n_pass++;
      n_total++; if (w_dcod_cnt !== 4'd1) $display("FAIL wrap_narrow got=%0d exp=1", w_dcod_cnt); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_rtype();
      test_extension();
      test_backpressure();
      test_stream();
      test_flush();
      test_async_reset();
      test_wrap();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
